// File: rtl/sky130_fd_io__sio_bank_seq.sv
// SIO bank control sequencer: ENABLE_H / HLD_H_N power-up and hold sequencing,
// per-channel config shadow with legality checks, and synchronised pad inputs.

module sky130_fd_io__sio_bank_seq_lane #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr,
   input  logic [10:0] wdata,
   input  logic [1:0]  mode,
   input  logic        in_pad,
   input  logic        in_en,
   output logic [10:0] ctl,
   output logic        in_sync,
   output logic        in_rise,
   output logic        in_fall
);
   localparam logic [1:0]  MODE_RST = 2'd0;
   localparam logic [1:0]  MODE_SHD = 2'd1;
   localparam logic [1:0]  MODE_OVR = 2'd2;
   // OE_N is the only control that resets high
   localparam logic [10:0] CTL_RST  = 11'h008;

   logic [10:0]            shadow, shadow_nxt, ctl_nxt;
   logic [SYNC_STAGES-1:0] sync;

   always_comb begin
      shadow_nxt = wr ? wdata : shadow;
      ctl_nxt    = ctl;
      case (mode)
         MODE_RST: ctl_nxt = CTL_RST;
         MODE_SHD: ctl_nxt = shadow_nxt;
         // held pad: only OUT/OE_N move, and only when this pad drives HLD_OVR
         MODE_OVR: if (wr && ctl[10]) ctl_nxt[4:3] = wdata[4:3];
         default:  ctl_nxt = ctl;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow  <= CTL_RST;
         ctl     <= CTL_RST;
         sync    <= '0;
         in_rise <= 1'b0;
         in_fall <= 1'b0;
      end else begin
         shadow  <= shadow_nxt;
         ctl     <= ctl_nxt;
         sync    <= {sync[SYNC_STAGES-2:0], in_pad};
         in_rise <= in_en &  sync[SYNC_STAGES-2] & ~sync[SYNC_STAGES-1];
         in_fall <= in_en & ~sync[SYNC_STAGES-2] &  sync[SYNC_STAGES-1];
      end
   end

   assign in_sync = sync[SYNC_STAGES-1];
endmodule

module sky130_fd_io__sio_bank_seq #(
   parameter int NCH         = 2,
   parameter int SETTLE_CYC  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RESET_B,
   input  logic             PWR_GOOD,
   input  logic             CMD_HOLD,
   input  logic             CMD_RELEASE,
   input  logic             CFG_WE,
   input  logic [3:0]       CFG_SEL,
   input  logic [10:0]      CFG_DATA,
   input  logic [NCH-1:0]   IN_PAD,
   output logic             ENABLE_H,
   output logic             HLD_H_N,
   output logic [3*NCH-1:0] DM,
   output logic [NCH-1:0]   OE_N,
   output logic [NCH-1:0]   OUT,
   output logic [NCH-1:0]   SLOW,
   output logic [NCH-1:0]   VTRIP_SEL,
   output logic [NCH-1:0]   INP_DIS,
   output logic [NCH-1:0]   VREG_EN,
   output logic [NCH-1:0]   IBUF_SEL,
   output logic [NCH-1:0]   HLD_OVR,
   output logic [NCH-1:0]   IN_SYNC,
   output logic [NCH-1:0]   IN_RISE,
   output logic [NCH-1:0]   IN_FALL,
   output logic [2:0]       STATE,
   output logic             BUSY,
   output logic             ERR
);
   typedef enum logic [2:0] {
      S_OFF     = 3'd0,
      S_SETTLE  = 3'd1,
      S_ARM     = 3'd2,
      S_ACTIVE  = 3'd3,
      S_HOLD    = 3'd4,
      S_RELEASE = 3'd5
   } state_t;

   localparam logic [1:0]   MODE_RST = 2'd0;
   localparam logic [1:0]   MODE_SHD = 2'd1;
   localparam logic [1:0]   MODE_OVR = 2'd2;
   localparam int           CW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

   state_t                 state, nstate;
   logic [CW-1:0]          cnt, cnt_nxt;
   logic [SYNC_STAGES-1:0] pg_chain;
   logic                   pg_sync, cnt_done, timed;
   logic                   st_ok, sel_ok, dm_ok, accept;
   logic [1:0]             mode;
   logic [NCH-1:0][10:0]   ctl;

   assign pg_sync  = pg_chain[SYNC_STAGES-1];
   assign cnt_done = (cnt == CNT_LAST);

   always_comb begin
      nstate = state;
      if (!pg_sync) nstate = S_OFF;
      else begin
         case (state)
            S_OFF:     nstate = S_SETTLE;
            S_SETTLE:  if (cnt_done) nstate = S_ARM;
            S_ARM:     nstate = S_ACTIVE;
            S_ACTIVE:  if (CMD_HOLD) nstate = S_HOLD;
            S_HOLD:    if (CMD_RELEASE) nstate = S_RELEASE;
            S_RELEASE: if (cnt_done) nstate = S_ACTIVE;
            default:   nstate = S_OFF;
         endcase
      end
   end

   always_comb begin
      timed   = (state == S_SETTLE) || (state == S_RELEASE);
      cnt_nxt = (timed && nstate == state) ? cnt + 1'b1 : '0;
   end

   // writes are judged against the pre-edge state
   always_comb begin
      st_ok  = (state == S_ACTIVE) || (state == S_HOLD);
      sel_ok = ({1'b0, CFG_SEL} < 5'(NCH));
      dm_ok  = (CFG_DATA[2:0] == 3'b011) || (CFG_DATA[2:0] == 3'b101) ||
               (CFG_DATA[2:0] == 3'b110);
      accept = CFG_WE && st_ok && sel_ok && (!CFG_DATA[8] || dm_ok);
   end

   always_comb begin
      mode = MODE_SHD;
      if (nstate == S_OFF || nstate == S_SETTLE)    mode = MODE_RST;
      else if (state == S_HOLD && nstate == S_HOLD) mode = MODE_OVR;
   end

   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         pg_chain <= '0;
         state    <= S_OFF;
         cnt      <= '0;
         ENABLE_H <= 1'b0;
         HLD_H_N  <= 1'b0;
         BUSY     <= 1'b1;
         ERR      <= 1'b0;
      end else begin
         pg_chain <= {pg_chain[SYNC_STAGES-2:0], PWR_GOOD};
         state    <= nstate;
         cnt      <= cnt_nxt;
         ENABLE_H <= (nstate != S_OFF) && (nstate != S_SETTLE);
         HLD_H_N  <= (nstate == S_ACTIVE);
         BUSY     <= !((nstate == S_ACTIVE) || (nstate == S_HOLD));
         ERR      <= CFG_WE && !accept;
      end
   end

   assign STATE = state;

   for (genvar i = 0; i < NCH; i++) begin : g_lane
      sky130_fd_io__sio_bank_seq_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
         .clk     (CLK),
         .rst_n   (RESET_B),
         .wr      (accept && (CFG_SEL == 4'(i))),
         .wdata   (CFG_DATA),
         .mode    (mode),
         .in_pad  (IN_PAD[i]),
         .in_en   (nstate != S_OFF),
         .ctl     (ctl[i]),
         .in_sync (IN_SYNC[i]),
         .in_rise (IN_RISE[i]),
         .in_fall (IN_FALL[i])
      );
      assign DM[3*i +: 3] = ctl[i][2:0];
      assign OE_N[i]      = ctl[i][3];
      assign OUT[i]       = ctl[i][4];
      assign SLOW[i]      = ctl[i][5];
      assign VTRIP_SEL[i] = ctl[i][6];
      assign INP_DIS[i]   = ctl[i][7];
      assign VREG_EN[i]   = ctl[i][8];
      assign IBUF_SEL[i]  = ctl[i][9];
      assign HLD_OVR[i]   = ctl[i][10];
   end
endmodule
